// File: rtl/mips_cpu_pkg.sv
// Shared CPU package: memory/register types plus the data-memory arbiter enums.
package mips_cpu_pkg;
  localparam int DM_ADDR_W = 10;

  typedef logic [DM_ADDR_W-1:0] dm_addr_t;
  typedef logic [31:0]          reg_t;

  localparam reg_t ZERO = 32'h0000_0000;

  typedef enum logic {NORMAL, BOOST} dm_arb_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_LDR} dm_owner_t;
endpackage

// File: rtl/dm_arbiter.sv
// Data-memory arbiter: CPU-priority access with a starvation boost for the loader,
// and routing of the one-cycle-late read data back to the issuing requester.
//
// state  | meaning
// NORMAL | CPU has priority; loader served only when CPU is idle
// BOOST  | loader starved too long; it wins the next cycle it requests
module dm_arbiter
  import mips_cpu_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic     cpu_clk_50M,
  input  logic     cpu_rst,
  input  logic     cpu_req,
  input  logic     cpu_we,
  input  dm_addr_t cpu_addr,
  input  reg_t     cpu_wdata,
  output logic     cpu_gnt,
  output logic     cpu_rvalid,
  output reg_t     cpu_rdata,
  input  logic     ldr_req,
  input  logic     ldr_we,
  input  dm_addr_t ldr_addr,
  input  reg_t     ldr_wdata,
  output logic     ldr_gnt,
  output logic     ldr_rvalid,
  output reg_t     ldr_rdata,
  output logic     dmce,
  output logic     dmwe,
  output dm_addr_t dmaddr,
  output reg_t     dmdin,
  input  reg_t     dmdout
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  dm_arb_state_t    state_q, state_d;
  dm_owner_t        resp_owner_q, resp_owner_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             ldr_denied;

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q      <= NORMAL;
      resp_owner_q <= OWN_NONE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      resp_owner_q <= resp_owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Grants are masked during reset so memory stays untouched while cpu_rst is high.
  always_comb begin
    cpu_gnt = 1'b0;
    ldr_gnt = 1'b0;
    if (!cpu_rst) begin
      if (state_q == BOOST) begin
        ldr_gnt = ldr_req;
        cpu_gnt = cpu_req & ~ldr_req;
      end else begin
        cpu_gnt = cpu_req;
        ldr_gnt = ldr_req & ~cpu_req;
      end
    end
  end

  always_comb begin
    dmce   = cpu_gnt | ldr_gnt;
    dmwe   = 1'b0;
    dmaddr = dm_addr_t'(ZERO);
    dmdin  = ZERO;
    if (cpu_gnt) begin
      dmwe   = cpu_we;
      dmaddr = cpu_addr;
      dmdin  = cpu_wdata;
    end else if (ldr_gnt) begin
      dmwe   = ldr_we;
      dmaddr = ldr_addr;
      dmdin  = ldr_wdata;
    end
  end

  always_comb begin
    resp_owner_d = OWN_NONE;
    if (cpu_gnt && !cpu_we)      resp_owner_d = OWN_CPU;
    else if (ldr_gnt && !ldr_we) resp_owner_d = OWN_LDR;
  end

  assign cpu_rvalid = (resp_owner_q == OWN_CPU);
  assign ldr_rvalid = (resp_owner_q == OWN_LDR);
  assign cpu_rdata  = cpu_rvalid ? dmdout : ZERO;
  assign ldr_rdata  = ldr_rvalid ? dmdout : ZERO;

  assign ldr_denied = ldr_req & ~ldr_gnt;

  always_comb begin
    starve_cnt_d = '0;
    if (ldr_denied) begin
      if (starve_cnt_q == CNT_W'(STARVE_LIMIT)) starve_cnt_d = starve_cnt_q;
      else                                      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      NORMAL: if (ldr_denied && starve_cnt_q == CNT_W'(STARVE_LIMIT - 1)) state_d = BOOST;
      BOOST:  if (ldr_gnt || !ldr_req) state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end
endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: vector table against a behavioural single-port memory,
// plus a hand-written reset-during-read sequence.
module tb_dm_arbiter;
  import mips_cpu_pkg::*;

  logic     clk, rst;
  logic     cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  dm_addr_t cpu_addr;
  reg_t     cpu_wdata, cpu_rdata;
  logic     ldr_req, ldr_we, ldr_gnt, ldr_rvalid;
  dm_addr_t ldr_addr;
  reg_t     ldr_wdata, ldr_rdata;
  logic     dmce, dmwe;
  dm_addr_t dmaddr;
  reg_t     dmdin, dmdout;

  int checks = 0;
  int failures = 0;

  dm_arbiter #(.STARVE_LIMIT(4)) dut (
    .cpu_clk_50M(clk), .cpu_rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
    .dmce(dmce), .dmwe(dmwe), .dmaddr(dmaddr), .dmdin(dmdin), .dmdout(dmdout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  reg_t mem [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = ZERO;
    dmdout = ZERO;
  end
  always @(posedge clk) begin
    if (dmce) begin
      if (dmwe) mem[dmaddr] <= dmdin;
      else      dmdout      <= mem[dmaddr];
    end
  end

  typedef struct {
    logic cr, cw; logic [9:0] ca; logic [31:0] cd;
    logic lr, lw; logic [9:0] la; logic [31:0] ld;
    logic ecg, elg, ecv; logic [31:0] ecd; logic elv; logic [31:0] eld;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic cr, logic cw, logic [9:0] ca, logic [31:0] cd,
                              logic lr, logic lw, logic [9:0] la, logic [31:0] ld,
                              logic ecg, logic elg, logic ecv, logic [31:0] ecd,
                              logic elv, logic [31:0] eld);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.lr = lr; v.lw = lw; v.la = la; v.ld = ld;
    v.ecg = ecg; v.elg = elg; v.ecv = ecv; v.ecd = ecd; v.elv = elv; v.eld = eld;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [9:0] ca, input logic [31:0] cd,
                       input logic lr, input logic lw, input logic [9:0] la, input logic [31:0] ld);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    ldr_req = lr; ldr_we = lw; ldr_addr = la; ldr_wdata = ld;
  endtask

  initial begin
    logic        exp_we;
    logic [9:0]  exp_addr;
    logic [31:0] exp_din;

    rst = 1'b1;
    drive(1, 1, 10'h010, 32'h1234, 1, 1, 10'h020, 32'h5678);
    #2;
    chk("rst cpu_gnt", 32'(cpu_gnt), 0);
    chk("rst ldr_gnt", 32'(ldr_gnt), 0);
    chk("rst dmce", 32'(dmce), 0);
    chk("rst dmwe", 32'(dmwe), 0);
    chk("rst dmaddr", 32'(dmaddr), 0);
    chk("rst dmdin", dmdin, 0);
    chk("rst cpu_rvalid", 32'(cpu_rvalid), 0);
    chk("rst ldr_rvalid", 32'(ldr_rvalid), 0);
    chk("rst cpu_rdata", cpu_rdata, 0);
    chk("rst ldr_rdata", ldr_rdata, 0);
    @(posedge clk); @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    //        cr cw ca      cd            lr lw la      ld     ecg elg ecv ecd           elv eld
    vq.push_back(mk(0,0,10'h000,0,            0,0,10'h000,0,     0,0,0,0,            0,0));
    vq.push_back(mk(1,1,10'h010,32'hDEADBEEF, 0,0,10'h000,0,     1,0,0,0,            0,0));
    vq.push_back(mk(1,0,10'h010,0,            0,0,10'h000,0,     1,0,0,0,            0,0));
    vq.push_back(mk(0,0,10'h000,0,            0,0,10'h000,0,     0,0,1,32'hDEADBEEF, 0,0));
    vq.push_back(mk(1,1,10'h004,32'h11,       0,0,10'h000,0,     1,0,0,0,            0,0));
    vq.push_back(mk(0,0,10'h000,0,            1,1,10'h008,32'h22,0,1,0,0,            0,0));
    vq.push_back(mk(1,0,10'h004,0,            0,0,10'h000,0,     1,0,0,0,            0,0));
    vq.push_back(mk(0,0,10'h000,0,            1,0,10'h008,0,     0,1,1,32'h11,       0,0));
    vq.push_back(mk(1,0,10'h004,0,            0,0,10'h000,0,     1,0,0,0,            1,32'h22));
    vq.push_back(mk(0,0,10'h000,0,            0,0,10'h000,0,     0,0,1,32'h11,       0,0));
    vq.push_back(mk(1,1,10'h020,32'h5A,       1,0,10'h020,0,     1,0,0,0,            0,0));
    vq.push_back(mk(0,0,10'h000,0,            1,0,10'h020,0,     0,1,0,0,            0,0));
    vq.push_back(mk(0,0,10'h000,0,            0,0,10'h000,0,     0,0,0,0,            1,32'h5A));
    // Both requesting reads continuously: pattern CPU x4, loader x1, repeating
    vq.push_back(mk(1,0,10'h004,0,            1,0,10'h008,0,     1,0,0,0,            0,0));
    for (int k = 0; k < 3; k++)
      vq.push_back(mk(1,0,10'h004,0,          1,0,10'h008,0,     1,0,1,32'h11,       0,0));
    vq.push_back(mk(1,0,10'h004,0,            1,0,10'h008,0,     0,1,1,32'h11,       0,0));
    vq.push_back(mk(1,0,10'h004,0,            1,0,10'h008,0,     1,0,0,0,            1,32'h22));
    for (int k = 0; k < 3; k++)
      vq.push_back(mk(1,0,10'h004,0,          1,0,10'h008,0,     1,0,1,32'h11,       0,0));
    vq.push_back(mk(1,0,10'h004,0,            1,0,10'h008,0,     0,1,1,32'h11,       0,0));
    vq.push_back(mk(0,0,10'h000,0,            0,0,10'h000,0,     0,0,0,0,            1,32'h22));
    // Reach BOOST, then loader drops its request: CPU keeps priority afterwards
    for (int k = 0; k < 4; k++)
      vq.push_back(mk(1,1,10'h030,32'h40+k,   1,0,10'h008,0,     1,0,0,0,            0,0));
    vq.push_back(mk(1,1,10'h031,32'h77,       0,0,10'h000,0,     1,0,0,0,            0,0));
    vq.push_back(mk(1,1,10'h032,32'h78,       1,0,10'h008,0,     1,0,0,0,            0,0));
    vq.push_back(mk(0,0,10'h000,0,            0,0,10'h000,0,     0,0,0,0,            0,0));

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk); #1;
      drive(vq[i].cr, vq[i].cw, vq[i].ca, vq[i].cd, vq[i].lr, vq[i].lw, vq[i].la, vq[i].ld);
      @(negedge clk);
      exp_we   = vq[i].ecg ? vq[i].cw : (vq[i].elg ? vq[i].lw : 1'b0);
      exp_addr = vq[i].ecg ? vq[i].ca : (vq[i].elg ? vq[i].la : 10'h000);
      exp_din  = vq[i].ecg ? vq[i].cd : (vq[i].elg ? vq[i].ld : 32'h0);
      chk($sformatf("v%0d cpu_gnt", i), 32'(cpu_gnt), 32'(vq[i].ecg));
      chk($sformatf("v%0d ldr_gnt", i), 32'(ldr_gnt), 32'(vq[i].elg));
      chk($sformatf("v%0d dmce", i), 32'(dmce), 32'(vq[i].ecg | vq[i].elg));
      chk($sformatf("v%0d dmwe", i), 32'(dmwe), 32'(exp_we));
      chk($sformatf("v%0d dmaddr", i), 32'(dmaddr), 32'(exp_addr));
      chk($sformatf("v%0d dmdin", i), dmdin, exp_din);
      chk($sformatf("v%0d cpu_rvalid", i), 32'(cpu_rvalid), 32'(vq[i].ecv));
      chk($sformatf("v%0d cpu_rdata", i), cpu_rdata, vq[i].ecd);
      chk($sformatf("v%0d ldr_rvalid", i), 32'(ldr_rvalid), 32'(vq[i].elv));
      chk($sformatf("v%0d ldr_rdata", i), ldr_rdata, vq[i].eld);
    end

    // Reset pulsed in the cycle after a granted CPU read
    @(posedge clk); #1;
    drive(1, 0, 10'h010, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mid cpu_gnt", 32'(cpu_gnt), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1, 0, 10'h010, 0, 1, 0, 10'h008, 0);
    @(negedge clk);
    chk("mid rst cpu_rvalid", 32'(cpu_rvalid), 0);
    chk("mid rst cpu_rdata", cpu_rdata, 0);
    chk("mid rst dmce", 32'(dmce), 0);
    chk("mid rst cpu_gnt", 32'(cpu_gnt), 0);
    chk("mid rst ldr_gnt", 32'(ldr_gnt), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("post rst cpu_rvalid %0d", k), 32'(cpu_rvalid), 0);
      chk($sformatf("post rst ldr_rvalid %0d", k), 32'(ldr_rvalid), 0);
      @(posedge clk); #1;
    end
    // Fresh NORMAL state with a cleared counter: CPU wins four cycles, loader the fifth
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 10'h040, 32'h100 + k, 1, 1, 10'h041, 32'h200);
      @(negedge clk);
      chk($sformatf("post rst cpu_gnt c%0d", k), 32'(cpu_gnt), (k < 4) ? 1 : 0);
      chk($sformatf("post rst ldr_gnt c%0d", k), 32'(ldr_gnt), (k < 4) ? 0 : 1);
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mem 0x040", mem[10'h040], 32'h103);
    chk("mem 0x041", mem[10'h041], 32'h200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
